filter_iir1_lowpass_mc: RTL and testbench
=========================================

# filter_iir1_lowpass_mc

Parametrised, multi-channel first-order IIR lowpass for the composite encoder's chroma and amplitude paths. Time-multiplexes up to N_CH independent filters through one multiplier pipeline with per-channel state. Rounds intermediate results with round-half-up arithmetic shifts and clamps the output to the unsigned data range. It is the generic successor to the fixed 6-bit SECAM amplitude lowpass, and is used for SECAM Db/Dr amplitude and PAL/NTSC U/V band-limiting.

## Interface
- DW, 6: unsigned sample width (in/out)
- VW, 10: signed internal state width (v, feedback state)
- CW, 10: signed coefficient width
- N_CH, 1: channel count (1..16)
- FB, 96: feedback coefficient, applied directly with no sign inversion
- B0, 16: feedforward coefficient for the current v
- B1, 16: feedforward coefficient for the previous v
- AP, 7: fractional bits of FB
- BP, 7: fractional bits of B0/B1
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous zeroing of all channel state
- in_valid  in  1  sample strobe
- in_ch  in  max(1,$clog2(N_CH))  channel of sample
- in  in  DW  unsigned sample
- out_valid  out  1  result strobe
- out_ch  out  max(1,$clog2(N_CH))  channel of result
- out  out  DW  filtered, clamped sample

## Operation
- reduce(x,s) = (x + 2^(s-1)) >>> s, signed arithmetic.
- Per channel c, state r[c] (VW bits) and l[c] (signed, DW+2 bits), all 0 after reset.
- On an accepted sample x for c:
  - v = r[c] + x, truncated to VW (wraps, no saturation)
  - r[c] ← reduce(FB·v, AP)
  - l[c] ← reduce(B1·v, BP)
  - y = reduce(B0·v, BP) + old l[c]
- out = 0 if y<0, 2^DW−1 if y>2^DW−1, otherwise y.
- Channels are fully independent. Samples may arrive every cycle, in any channel order, with repeats allowed.
- clear: zeroes all r/l in the same cycle. It does not kill in-flight samples. A sample in stage 1 during clear uses the pre-clear state, and its state write is overridden by the zeroing (clear wins).
- in_ch ≥ N_CH: sample is dropped, no state change, no out_valid.

## Timing
- Pipeline stages:
  - S0 registers in/in_ch/in_valid.
  - S1 computes v, reads and updates state, and registers the B0 product, old l and channel.
  - S2 adds, clamps and registers out.
- Latency: in_valid at edge t → out_valid high for one cycle after edge t+3. Throughput is 1 sample per cycle.
- Back-to-back samples on the same channel: S1 reads state written the previous cycle; no stall, no bubble.
- Reset values: out=0, out_valid=0, out_ch=0, all state and pipeline valids 0. Reset asserted mid-stream discards in-flight samples with no spurious out_valid.
- out/out_ch hold their value while out_valid is low.

## Configuration
- FILTER_IIR_COEF_LOAD_EN defined:
  - Adds ports coef_we (1), coef_sel (2: 0=FB, 1=B0, 2=B1, 3=ignored) and coef_data (signed CW).
  - Coefficient registers reset to the FB/B0/B1 parameters and update on coef_we.
  - A new value applies from the next S1 cycle.
- Undefined: coefficients are the parameters as constants and the ports are absent.

## Structure
- filter_pkg holds the shared reduce() function, the channel-index width helper and the coef_sel enum.
- Sub-module filter_iir1_state_ram: N_CH×(VW+DW+2) register file with one combinational read, one write and a synchronous clear. Implemented as flops; no write-through needed given the read/write timing above.

## Test plan
- Defaults, ch0, constant x=40: outputs 5, 14, … converging to 40±1 within 30 samples; out_valid exactly 3 cycles after each in_valid.
- N_CH=2, interleaved ch0=40 and ch1=0: ch0 sequence matches the single-channel run (5, 14, …), ch1 stays 0.
- Step 63→0 on ch0: output undershoot clamps at 0, never wraps; step 0→63 clamps at 63.
- clear pulsed mid-stream after 10 samples of 40: the next sample of 40 yields 5 again.
- reset_n pulled low with 3 samples in flight: out_valid never asserts for them, out=0, and post-reset output for 40 is 5.
- With FILTER_IIR_COEF_LOAD_EN, load B1=0 then feed 40: first output 5, second output 9.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: shared arithmetic helper, channel-index width helper and coefficient-select codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package filter_pkg;

    // Coefficient register select codes used by the optional run-time load port.
    typedef enum logic [1:0] {
        COEF_FB   = 2'd0,
        COEF_B0   = 2'd1,
        COEF_B2X  = 2'd3,
        COEF_B1   = 2'd2
    } coef_sel_e;

    // Working width of reduce(). Every product that is passed in must fit in it.
    localparam int RED_W = 32;

    // Channel index width: a single-channel build still carries a 1-bit index.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Round-half-up arithmetic right shift: (x + 2^(s-1)) >>> s. Expects s >= 1.
    function automatic logic signed [RED_W-1:0] reduce(input logic signed [RED_W-1:0] x,
                                                       input int                       s);
        logic signed [RED_W-1:0] half;
        half = 32'sd1 <<< (s - 1);
        return (x + half) >>> s;
    endfunction

endpackage

// File: rtl/filter_iir1_state_ram.sv
// filter_iir1_state_ram: per-channel filter state register file (N_CH entries of W bits, flops).
// Latency: combinational read; a write becomes visible after the next clk edge.
// Backpressure: none; one read and one write every cycle, a synchronous clear overrides the write.
//
// Ports: clk, reset_n (async active-low), clear (zero every entry), rd_addr/rd_dat (read),
//        we/wr_addr/wr_dat (write).
module filter_iir1_state_ram #(
    parameter int N_CH = 1,
    parameter int W    = 18,
    parameter int AW   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat
);

    logic [W-1:0] mem [N_CH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_CH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_addr == AW'(i)) mem[i] <= wr_dat;
            end
        end
    end

    // Decoded read so that an index beyond N_CH-1 never addresses a missing row.
    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr == AW'(i)) rd_dat = mem[i];
        end
    end

endmodule

// File: rtl/filter_iir1_lowpass_mc.sv
// filter_iir1_lowpass_mc: time-multiplexed multi-channel first-order IIR lowpass, clamped unsigned output.
// Latency: 3 cycles from in_valid to out_valid (S0 input reg, S1 state/multiply, S2 add/clamp).
// Backpressure: none; accepts one sample per cycle in any channel order, same-channel back-to-back included.
//
// Ports: clk, reset_n (async active-low), clear (zero all channel state),
//        in_valid/in_ch/in (sample), out_valid/out_ch/out (result, held while out_valid is low).
// Build option: FILTER_IIR_COEF_LOAD_EN adds coef_we/coef_sel/coef_data for run-time FB/B0/B1 loading.
module filter_iir1_lowpass_mc
    import filter_pkg::*;
#(
    parameter int DW   = 6,
    parameter int VW   = 10,
    parameter int CW   = 10,
    parameter int N_CH = 1,
    parameter int FB   = 96,
    parameter int B0   = 16,
    parameter int B1   = 16,
    parameter int AP   = 7,
    parameter int BP   = 7,
    localparam int CHW = ch_width(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [CHW-1:0]       in_ch,
    input  logic [DW-1:0]        in,
`ifdef FILTER_IIR_COEF_LOAD_EN
    input  logic                 coef_we,
    input  logic [1:0]           coef_sel,
    input  logic signed [CW-1:0] coef_data,
`endif
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic [DW-1:0]        out
);

    localparam int LW = DW + 2;   // l state width
    localparam int SW = VW + LW;  // packed {r, l} state row
    localparam int PW = CW + VW;  // full product width
    localparam int YW = PW + 1;   // sum width before clamping
    localparam logic signed [YW-1:0] Y_MAX = YW'((1 << DW) - 1);

    // ---------------- coefficients ----------------
    logic signed [CW-1:0] c_fb, c_b0, c_b1;

`ifdef FILTER_IIR_COEF_LOAD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_fb <= CW'(FB);
            c_b0 <= CW'(B0);
            c_b1 <= CW'(B1);
        end else if (coef_we) begin
            case (coef_sel_e'(coef_sel))
                COEF_FB: c_fb <= coef_data;
                COEF_B0: c_b0 <= coef_data;
                COEF_B1: c_b1 <= coef_data;
                default: ;
            endcase
        end
    end
`else
    assign c_fb = CW'(FB);
    assign c_b0 = CW'(B0);
    assign c_b1 = CW'(B1);
`endif

    // ---------------- S0: input register ----------------
    logic           s0_vld;
    logic [CHW-1:0] s0_ch;
    logic [DW-1:0]  s0_x;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_vld <= 1'b0;
            s0_ch  <= '0;
            s0_x   <= '0;
        end else begin
            // Out-of-range channels are dropped here so they never touch state or output.
            s0_vld <= in_valid && (int'(in_ch) < N_CH);
            s0_ch  <= in_ch;
            s0_x   <= in;
        end
    end

    // ---------------- S1: state read, multiply, state write ----------------
    logic [SW-1:0]        st_rd;
    logic signed [VW-1:0] r_old, v, r_new;
    logic signed [LW-1:0] l_old, l_new;
    logic signed [PW-1:0] p_fb, p_b0, p_b1;

    assign r_old = st_rd[SW-1:LW];
    assign l_old = st_rd[LW-1:0];
    assign v     = r_old + $signed(VW'(s0_x));  // wraps at VW bits
    assign p_fb  = PW'(c_fb) * PW'(v);
    assign p_b0  = PW'(c_b0) * PW'(v);
    assign p_b1  = PW'(c_b1) * PW'(v);
    assign r_new = VW'(reduce(RED_W'(p_fb), AP));
    assign l_new = LW'(reduce(RED_W'(p_b1), BP));

    // Write lands at the end of this cycle, so a same-channel sample in S1 next cycle
    // reads the updated row directly; clear inside the RAM takes priority over this write.
    filter_iir1_state_ram #(
        .N_CH (N_CH),
        .W    (SW),
        .AW   (CHW)
    ) u_state (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .rd_addr (s0_ch),
        .rd_dat  (st_rd),
        .we      (s0_vld),
        .wr_addr (s0_ch),
        .wr_dat  ({r_new, l_new})
    );

    logic                 s1_vld;
    logic [CHW-1:0]       s1_ch;
    logic signed [PW-1:0] s1_b0;
    logic signed [LW-1:0] s1_l;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_ch  <= '0;
            s1_b0  <= '0;
            s1_l   <= '0;
        end else begin
            s1_vld <= s0_vld;
            if (s0_vld) begin
                s1_ch <= s0_ch;
                s1_b0 <= PW'(reduce(RED_W'(p_b0), BP));
                s1_l  <= l_old;
            end
        end
    end

    // ---------------- S2: sum, clamp, output register ----------------
    logic signed [YW-1:0] y;
    logic [DW-1:0]        y_clamp;

    always_comb begin
        y = YW'(s1_b0) + YW'(s1_l);
        if (y[YW-1])       y_clamp = '0;
        else if (y > Y_MAX) y_clamp = '1;
        else               y_clamp = y[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out       <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_ch <= s1_ch;
                out    <= y_clamp;
            end
        end
    end

endmodule

// File: tb/tb_filter_iir1_lowpass_mc.sv
// tb_filter_iir1_lowpass_mc: scoreboard bench for two filter instances sharing one input stream.
// Instance 0 uses the default coefficients; instance 1 uses a negative FB and large B0/B1
// so that both output clamps are reachable.
module tb_filter_iir1_lowpass_mc;

    localparam int NCH = 3;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       clear    = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_ch    = 2'd0;
    logic [5:0] in_s     = 6'd0;
    logic       ov0, ov1;
    logic [1:0] oc0, oc1;
    logic [5:0] o0, o1;
`ifdef FILTER_IIR_COEF_LOAD_EN
    logic              coef_we   = 1'b0;
    logic [1:0]        coef_sel  = 2'd0;
    logic signed [9:0] coef_data = 10'sd0;
`endif

    filter_iir1_lowpass_mc #(.N_CH(NCH)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ch(in_ch), .in(in_s),
`ifdef FILTER_IIR_COEF_LOAD_EN
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_data(coef_data),
`endif
        .out_valid(ov0), .out_ch(oc0), .out(o0)
    );

    filter_iir1_lowpass_mc #(.N_CH(NCH), .FB(-96), .B0(200), .B1(200)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ch(in_ch), .in(in_s),
`ifdef FILTER_IIR_COEF_LOAD_EN
        .coef_we(coef_we), .coef_sel(coef_sel), .coef_data(coef_data),
`endif
        .out_valid(ov1), .out_ch(oc1), .out(o1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int y; int ch; int cyc; } exp_t;
    typedef struct { int y; int ch; } got_t;

    exp_t sb  [2][$];
    got_t got [2][$];
    int   rm [2][NCH];
    int   lm [2][NCH];
    int   cfb [2];
    int   cb0 [2];
    int   cb1 [2];
    int   hold_y [2];
    int   hold_c [2];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int red(input int x, input int s);
        return (x + (1 << (s - 1))) >>> s;
    endfunction

    function automatic int wrap(input int x, input int w);
        return (x <<< (32 - w)) >>> (32 - w);
    endfunction

    // Reference filter step for instance k; pushes the expected result and its arrival cycle.
    task automatic model(input int k, input int ch, input int x);
        int   v, y;
        exp_t e;
        v = wrap(rm[k][ch] + x, 10);
        y = red(cb0[k] * v, 7) + lm[k][ch];
        rm[k][ch] = wrap(red(cfb[k] * v, 7), 10);
        lm[k][ch] = wrap(red(cb1[k] * v, 7), 8);
        if (y < 0)  y = 0;
        if (y > 63) y = 63;
        e = '{y, ch, cyc + 3};
        sb[k].push_back(e);
    endtask

    task automatic zero_model();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++) begin
                rm[k][c] = 0;
                lm[k][c] = 0;
            end
    endtask

    task automatic send(input int ch, input int x);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_s     = 6'(x);
        if (ch < NCH) begin
            model(0, ch, x);
            model(1, ch, x);
        end
    endtask

    task automatic send_raw(input int ch, input int x);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_s     = 6'(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 30) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_timeout", sb[0].size() + sb[1].size(), 0);
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        zero_model();
    endtask

    task automatic clear_got();
        got[0].delete();
        got[1].delete();
    endtask

`ifdef FILTER_IIR_COEF_LOAD_EN
    task automatic load_coef(input int sel, input int val);
        @(posedge clk); #1;
        coef_we   = 1'b1;
        coef_sel  = 2'(sel);
        coef_data = 10'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask
`endif

    // i-th output of channel ch from instance k, -1 when absent.
    function automatic int gy(input int k, input int ch, input int i);
        int n;
        n = 0;
        foreach (got[k][j]) begin
            if (got[k][j].ch == ch) begin
                if (n == i) return got[k][j].y;
                n++;
            end
        end
        return -1;
    endfunction

    task automatic mon(input int k, input logic ov, input logic [1:0] oc, input logic [5:0] oy);
        exp_t e;
        got_t g;
        if (!reset_n) begin
            hold_y[k] = 0;
            hold_c[k] = 0;
        end else if (ov === 1'b1) begin
            g = '{int'(oy), int'(oc)};
            got[k].push_back(g);
            check($sformatf("unexpected_out%0d", k), 32'(sb[k].size() != 0), 1);
            if (sb[k].size() != 0) begin
                e = sb[k].pop_front();
                check($sformatf("out%0d", k), oy, e.y);
                check($sformatf("out_ch%0d", k), oc, e.ch);
                check($sformatf("latency%0d", k), cyc, e.cyc);
            end
            hold_y[k] = oy;
            hold_c[k] = oc;
        end else begin
            check($sformatf("hold_out%0d", k), oy, hold_y[k]);
            check($sformatf("hold_ch%0d", k), oc, hold_c[k]);
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, oc0, o0);
        mon(1, ov1, oc1, o1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cfb[0] = 96;  cb0[0] = 16;  cb1[0] = 16;
        cfb[1] = -96; cb0[1] = 200; cb1[1] = 200;
        zero_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out0", o0, 0);
        check("rst_vld0", ov0, 0);
        check("rst_ch0", oc0, 0);
        check("rst_out1", o1, 0);
        check("rst_vld1", ov1, 0);
        reset_n = 1'b1;

        // Constant 40 on ch0, back-to-back
        clear_got();
        for (int i = 0; i < 30; i++) send(0, 40);
        drain();
        check("c40_n0", gy(0, 0, 0), 5);
        check("c40_n1", gy(0, 0, 1), 14);
        check("c40_n2", gy(0, 0, 2), 21);
        check("c40_settled", 32'(gy(0, 0, 29) >= 39 && gy(0, 0, 29) <= 41), 1);

        // Interleaved channels with out-of-range samples mixed in
        clear_pulse();
        clear_got();
        for (int i = 0; i < 10; i++) begin
            send(0, 40);
            send(1, 0);
            send(3, 50);
        end
        drain();
        check("il_ch0_n0", gy(0, 0, 0), 5);
        check("il_ch0_n1", gy(0, 0, 1), 14);
        check("il_ch1_n0", gy(0, 1, 0), 0);
        check("il_ch1_n9", gy(0, 1, 9), 0);
        check("il_count", got[0].size(), 20);

        // Step up then down on ch0
        clear_pulse();
        clear_got();
        for (int i = 0; i < 25; i++) send(0, 63);
        for (int i = 0; i < 25; i++) send(0, 0);
        drain();
        check("step_up_n0", gy(0, 0, 0), 8);
        check("step_dn_last", gy(0, 0, 49), 0);

        // Both clamps on instance 1: 63 then 0, 0 gives raw 98, 25, -18
        clear_pulse();
        clear_got();
        send(2, 63);
        send(2, 0);
        send(2, 0);
        drain();
        check("clamp_hi", gy(1, 2, 0), 63);
        check("clamp_mid", gy(1, 2, 1), 25);
        check("clamp_lo", gy(1, 2, 2), 0);

        // clear after 10 samples of 40 restarts the response
        clear_pulse();
        clear_got();
        for (int i = 0; i < 10; i++) send(0, 40);
        drain();
        clear_pulse();
        send(0, 40);
        drain();
        check("clr_restart", gy(0, 0, 10), 5);

        // Reset with three samples in flight
        clear_got();
        send_raw(0, 40);
        send_raw(1, 40);
        send_raw(0, 40);
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstf_vld0", ov0, 0);
            check("rstf_out0", o0, 0);
            check("rstf_vld1", ov1, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        zero_model();
        send(0, 40);
        drain();
        check("rstf_post", gy(0, 0, 0), 5);
        check("rstf_count", got[0].size(), 1);

`ifdef FILTER_IIR_COEF_LOAD_EN
        // Slot 3 is ignored; B1 = 0 removes the previous-v term
        load_coef(3, 77);
        load_coef(2, 0);
        cb1[0] = 0;
        cb1[1] = 0;
        clear_pulse();
        clear_got();
        send(0, 40);
        send(0, 40);
        drain();
        check("coef_n0", gy(0, 0, 0), 5);
        check("coef_n1", gy(0, 0, 1), 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
